if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-004 br_bus  input  34  {br_stall[33], br_taken[32], br_target[31:0]} from decode.
REQ-005 fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction for decode.
REQ-006 fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
REQ-007 inst_sram_en  output  1  instruction SRAM read enable.
REQ-008 inst_sram_we  output  4  byte write enables; constant 4'h0.
REQ-009 inst_sram_addr  output  32  fetch address; always equals nextpc.
REQ-010 inst_sram_wdata  output  32  constant 32'h0.
REQ-011 inst_sram_rdata  input  32  read data, valid one cycle after the cycle inst_sram_en is sampled high.

Function
REQ-012 Two sub-stages: pre-IF (address generation, to_fs_valid register) and IF (fs_valid, fs_pc, instruction buffer).
REQ-013 to_fs_valid SHALL go to 1 on the first rising edge after resetn deasserts and stay 1.
REQ-014 seq_pc = fs_pc + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-015 nextpc = br_taken ? br_target : seq_pc.
REQ-016 fs_ready_go is constant 1.
REQ-017 fs_allowin = !fs_valid | ds_allowin | br_taken.
REQ-018 Fetch issue condition: to_fs_valid & fs_allowin & !br_stall.
REQ-019 inst_sram_en = 1 only when the fetch issue condition holds; otherwise 0.
REQ-020 On an edge where the fetch issue condition holds: fs_valid <= 1 and fs_pc <= nextpc.
REQ-021 On an edge where fs_valid = 1 and ds_allowin = 1, with no fetch issued: fs_valid <= 0.
REQ-022 When br_stall = 1: no fetch is issued, and fs_valid, fs_pc and the buffer hold their values.
REQ-023 br_stall takes priority over br_taken.
REQ-024 fs_to_ds_valid = fs_valid & !br_taken.
  - A wrong-path instruction is never presented to decode in any cycle where br_taken = 1.
  - That wrong-path instruction is discarded on the next edge, unless br_stall = 1.
REQ-025 While br_taken stays high for several cycles:
  - every cycle re-issues a fetch of br_target;
  - fs_to_ds_valid stays 0;
  - after br_taken falls, fs presents {inst@br_target, br_target}.
REQ-026 Instruction buffer (inst_buf, inst_buf_valid) captures inst_sram_rdata on the first edge with fs_valid & !ds_allowin & !br_taken & !inst_buf_valid.
REQ-027 fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-028 inst_buf_valid is cleared on any edge where fs hands off (fs_valid & ds_allowin), is cancelled (br_taken & !br_stall), or a fetch is issued.
REQ-029 fs_to_ds_bus SHALL stay constant while fs_to_ds_valid = 1 and ds_allowin = 0, regardless of inst_sram_rdata changes.
REQ-030 Handshake: an instruction transfers to decode on an edge with fs_to_ds_valid = 1 and ds_allowin = 1.
  - Each fetched instruction transfers exactly once or is cancelled.
  - No instruction is duplicated or skipped on the sequential path.

Reset
REQ-031 resetn low SHALL immediately (asynchronously) set:
  - to_fs_valid = 0, fs_valid = 0, inst_buf_valid = 0;
  - fs_pc = 32'h1BFF_FFFC, inst_buf = 0.
REQ-032 Outputs while in reset:
  - fs_to_ds_valid = 0, inst_sram_en = 0, inst_sram_we = 0, inst_sram_wdata = 0;
  - inst_sram_addr = 32'h1C00_0000.
REQ-033 resetn asserted mid-operation discards every in-flight fetch; after release, fetch restarts at 32'h1C00_0000.

Verification
REQ-034 Release resetn, ds_allowin = 1, br_bus = 0, SRAM returns the address as data:
  - inst_sram_en = 1 with addr 0x1C000000 on the first cycle after release;
  - addr increments by 4 each cycle;
  - one cycle later fs_to_ds_bus = {0x1C000000, 0x1C000000} with fs_to_ds_valid = 1.
REQ-035 Hold ds_allowin = 0 for 3 cycles while fs_valid = 1 and randomize rdata:
  - inst_sram_en = 0 throughout;
  - fs_to_ds_bus unchanged;
  - on ds_allowin = 1 the buffered instruction transfers, then sequential fetch resumes.
REQ-036 Single-cycle br_taken = 1, br_target = 0x1C000100:
  - fs_to_ds_valid = 0 that cycle;
  - inst_sram_addr = 0x1C000100;
  - next cycle fs_pc = 0x1C000100, fs_to_ds_valid = 1.
REQ-037 br_taken = 1 held 3 cycles with ds_allowin = 0:
  - a fetch of br_target is issued each cycle;
  - fs_to_ds_valid = 0 throughout;
  - after br_taken drops, {inst@target, target} is valid.
REQ-038 br_stall = 1 (with br_taken = 1) for 2 cycles:
  - inst_sram_en = 0;
  - fs_pc and fs_valid held;
  - fs_to_ds_valid = 0;
  - on release with br_taken, the fetch goes to br_target.
REQ-039 Pull resetn low mid-stream (async, between edges):
  - fs_to_ds_valid and inst_sram_en drop to 0 without a clock edge;
  - inst_sram_addr = 0x1C000000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF address generation and IF stage with a one-entry instruction hold buffer.
// Latency: an instruction is presented to decode one cycle after its SRAM read is issued.
// Backpressure: ds_allowin low blocks new fetches; the returned word is parked in inst_buf until handoff.
module if_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);
    localparam logic [31:0] RESET_PC = 32'h1BFF_FFFC;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_t;

    br_t         br;
    logic        to_fs_valid;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fetch;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;
    logic        buf_clear;
    logic        buf_capture;

    assign br          = br_t'(br_bus);
    assign fs_ready_go = 1'b1;
    assign seq_pc      = fs_pc + 32'd4;
    assign nextpc      = br.taken ? br.target : seq_pc;
    assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin) || br.taken;
    assign fetch       = to_fs_valid && fs_allowin && !br.stall;

    assign inst_sram_en    = fetch;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

    // A taken branch means the instruction in IF is wrong-path, so it is never offered.
    assign fs_inst        = inst_buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_valid = fs_valid && fs_ready_go && !br.taken;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};

    assign buf_clear   = (fs_valid && ds_allowin) || br.taken || fetch;
    assign buf_capture = fs_valid && !ds_allowin && !br.taken && !inst_buf_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_fs_valid <= 1'b0;
        end else begin
            to_fs_valid <= 1'b1;
        end
    end

    // br_stall freezes the whole IF stage, including a pending handoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC;
        end else if (!br.stall) begin
            if (fetch) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end else if (fs_valid && ds_allowin) begin
                fs_valid <= 1'b0;
            end
        end
    end

    // SRAM data is only valid for one cycle, so it is captured the first cycle decode refuses it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'h0;
        end else if (!br.stall) begin
            if (buf_clear) begin
                inst_buf_valid <= 1'b0;
            end else if (buf_capture) begin
                inst_buf_valid <= 1'b1;
                inst_buf       <= inst_sram_rdata;
            end
        end
    end
endmodule
